// File: rtl/obstacle_field_ctrl.sv
// Obstacle field game-state stage: scrolls, retires and spawns obstacles once
// per frame tick, feeding registered slot geometry to the renderer.
//
// mode | meaning
// 00   | menu  : field cleared every clock, pass counter and spawn gap reset
// 01   | run   : on frame_tick move, retire and spawn
// 10   | pause : everything holds, ticks ignored
// 11   | over  : everything holds, ticks ignored
module obstacle_field_ctrl #(
  parameter int          NUM_OBS   = 10,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          OBS_W     = 40,
  parameter int          OBS_H     = 40,
  parameter int          SPEED     = 4,
  parameter int          SPAWN_GAP = 80,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic [1:0]              gamemode,
  output logic [NUM_OBS-1:0][9:0] obstacle_x_game_left,
  output logic [NUM_OBS-1:0][9:0] obstacle_x_game_right,
  output logic [NUM_OBS-1:0][8:0] obstacle_y_game_up,
  output logic [NUM_OBS-1:0][8:0] obstacle_y_game_down,
  output logic [NUM_OBS-1:0]      obs_active,
  output logic [15:0]             obs_passed
);

  typedef enum logic [1:0] {
    MODE_MENU  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_OVER  = 2'b11
  } mode_t;

  localparam int GAP_W = $clog2(SPAWN_GAP + SPEED + 1);

  localparam logic [9:0]       X_PARK    = 10'(SCREEN_W);
  localparam logic [9:0]       X_SPAWN_R = 10'(SCREEN_W + OBS_W);
  localparam logic [9:0]       X_STEP    = 10'(SPEED);
  localparam logic [8:0]       Y_MAX     = 9'(SCREEN_H - OBS_H);
  localparam logic [8:0]       Y_HEIGHT  = 9'(OBS_H);
  localparam logic [GAP_W-1:0] GAP_FULL  = GAP_W'(SPAWN_GAP);
  localparam logic [GAP_W-1:0] GAP_STEP  = GAP_W'(SPEED);

  logic [NUM_OBS-1:0][9:0] left_q,  left_nxt;
  logic [NUM_OBS-1:0][9:0] right_q, right_nxt;
  logic [NUM_OBS-1:0][8:0] up_q,    up_nxt;
  logic [NUM_OBS-1:0][8:0] down_q,  down_nxt;
  logic [NUM_OBS-1:0]      active_q, active_nxt;
  logic [15:0]             passed_q, passed_nxt;
  logic [GAP_W-1:0]        gap_q,    gap_nxt;
  logic [15:0]             lfsr_q,   lfsr_nxt;

  mode_t                   mode;
  logic [NUM_OBS-1:0]      free_mask;
  logic [NUM_OBS-1:0]      spawn_oh;
  logic [8:0]              y_raw;
  logic [8:0]              y_spawn;
  logic [15:0]             lfsr_adv;
  logic [GAP_W-1:0]        gap_sum;

  assign mode      = mode_t'(gamemode);
  // Spawn target is chosen from the pre-tick mask, so a slot retiring this
  // tick is not reused until the following tick.
  assign free_mask = ~active_q;
  assign spawn_oh  = free_mask & (~free_mask + {{(NUM_OBS-1){1'b0}}, 1'b1});
  // Fold the 9-bit LFSR slice into 0..Y_MAX so the obstacle stays on screen.
  assign y_raw     = lfsr_q[8:0];
  assign y_spawn   = (y_raw > Y_MAX) ? (y_raw - (Y_MAX + 9'd1)) : y_raw;
  assign lfsr_adv  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign gap_sum   = gap_q + GAP_STEP;

  // Next-state: per-mode field update, RUN work only on frame_tick.
  always_comb begin
    left_nxt   = left_q;
    right_nxt  = right_q;
    up_nxt     = up_q;
    down_nxt   = down_q;
    active_nxt = active_q;
    passed_nxt = passed_q;
    gap_nxt    = gap_q;
    lfsr_nxt   = lfsr_q;

    unique case (mode)
      MODE_MENU: begin
        for (int i = 0; i < NUM_OBS; i++) begin
          left_nxt[i]  = X_PARK;
          right_nxt[i] = X_PARK;
          up_nxt[i]    = 9'd0;
          down_nxt[i]  = 9'd0;
        end
        active_nxt = '0;
        passed_nxt = 16'd0;
        gap_nxt    = GAP_FULL;
      end
      MODE_RUN: begin
        if (frame_tick) begin
          for (int i = 0; i < NUM_OBS; i++) begin
            if (active_q[i]) begin
              if (right_q[i] <= X_STEP) begin
                left_nxt[i]   = X_PARK;
                right_nxt[i]  = X_PARK;
                up_nxt[i]     = 9'd0;
                down_nxt[i]   = 9'd0;
                active_nxt[i] = 1'b0;
                if (passed_nxt != 16'hFFFF) passed_nxt = passed_nxt + 16'd1;
              end else begin
                right_nxt[i] = right_q[i] - X_STEP;
                left_nxt[i]  = (left_q[i] >= X_STEP) ? (left_q[i] - X_STEP) : 10'd0;
              end
            end
          end
          if ((gap_q >= GAP_FULL) && (|free_mask)) begin
            for (int i = 0; i < NUM_OBS; i++) begin
              if (spawn_oh[i]) begin
                left_nxt[i]   = X_PARK;
                right_nxt[i]  = X_SPAWN_R;
                up_nxt[i]     = y_spawn;
                down_nxt[i]   = y_spawn + Y_HEIGHT;
                active_nxt[i] = 1'b1;
              end
            end
            gap_nxt  = GAP_STEP;
            lfsr_nxt = lfsr_adv;
          end else begin
            gap_nxt = (gap_sum >= GAP_FULL) ? GAP_FULL : gap_sum;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset parks every slot and reloads the spawn gap and LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        left_q[i]  <= X_PARK;
        right_q[i] <= X_PARK;
        up_q[i]    <= 9'd0;
        down_q[i]  <= 9'd0;
      end
      active_q <= '0;
      passed_q <= 16'd0;
      gap_q    <= GAP_FULL;
      lfsr_q   <= LFSR_SEED;
    end else begin
      left_q   <= left_nxt;
      right_q  <= right_nxt;
      up_q     <= up_nxt;
      down_q   <= down_nxt;
      active_q <= active_nxt;
      passed_q <= passed_nxt;
      gap_q    <= gap_nxt;
      lfsr_q   <= lfsr_nxt;
    end
  end

  assign obstacle_x_game_left  = left_q;
  assign obstacle_x_game_right = right_q;
  assign obstacle_y_game_up    = up_q;
  assign obstacle_y_game_down  = down_q;
  assign obs_active            = active_q;
  assign obs_passed            = passed_q;

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Bench for obstacle_field_ctrl: two instances (default spawn gap and a
// short gap that can fill every slot) checked against an age-based model.
module tb_obstacle_field_ctrl;

  localparam int NS    = 10;
  localparam int GAP_A = 80;
  localparam int GAP_B = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_tick;
  logic [1:0] gamemode;

  logic [9:0][9:0] left_a, right_a, left_b, right_b;
  logic [9:0][8:0] up_a, down_a, up_b, down_b;
  logic [9:0]      act_a, act_b;
  logic [15:0]     pass_a, pass_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obstacle_field_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x_game_left(left_a), .obstacle_x_game_right(right_a),
    .obstacle_y_game_up(up_a), .obstacle_y_game_down(down_a),
    .obs_active(act_a), .obs_passed(pass_a)
  );

  obstacle_field_ctrl #(.SPAWN_GAP(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x_game_left(left_b), .obstacle_x_game_right(right_b),
    .obstacle_y_game_up(up_b), .obstacle_y_game_down(down_b),
    .obs_active(act_b), .obs_passed(pass_b)
  );

  // Model: each live obstacle is described by its age in ticks and its y.
  int          m_act [2][NS];
  int          m_age [2][NS];
  int          m_y   [2][NS];
  int          m_passed [2];
  int          m_gap [2];
  logic [15:0] m_lfsr [2];

  function automatic int gap_lim(input int d);
    return (d == 0) ? GAP_A : GAP_B;
  endfunction

  // Polynomial x^16+x^14+x^13+x^11+1, shifted left, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    for (int k = 0; k < 4; k++) fb = fb ^ s[taps[k]-1];
    return {s[14:0], fb};
  endfunction

  function automatic int y_of(input logic [15:0] s);
    int r = int'(s[8:0]);
    return (r > 440) ? r - 441 : r;
  endfunction

  function automatic int e_left(input int d, input int i);
    int x;
    if (m_act[d][i] == 0) return 640;
    x = 640 - 4 * m_age[d][i];
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int e_right(input int d, input int i);
    return (m_act[d][i] != 0) ? 680 - 4 * m_age[d][i] : 640;
  endfunction

  function automatic int e_up(input int d, input int i);
    return (m_act[d][i] != 0) ? m_y[d][i] : 0;
  endfunction

  function automatic int e_down(input int d, input int i);
    return (m_act[d][i] != 0) ? m_y[d][i] + 40 : 0;
  endfunction

  function automatic int e_mask(input int d);
    int m = 0;
    for (int i = 0; i < NS; i++) if (m_act[d][i] != 0) m = m | (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NS; i++) begin
        m_act[d][i] = 0;
        m_age[d][i] = 0;
        m_y[d][i]   = 0;
      end
      m_passed[d] = 0;
      m_gap[d]    = gap_lim(d);
      m_lfsr[d]   = 16'hACE1;
    end
  endtask

  task automatic model_step(input int d);
    int pre [NS];
    int free;
    if (gamemode == 2'b00) begin
      for (int i = 0; i < NS; i++) m_act[d][i] = 0;
      m_passed[d] = 0;
      m_gap[d]    = gap_lim(d);
    end else if (gamemode == 2'b01 && frame_tick) begin
      for (int i = 0; i < NS; i++) pre[i] = m_act[d][i];
      for (int i = 0; i < NS; i++) begin
        if (pre[i] != 0) begin
          if (680 - 4 * m_age[d][i] <= 4) begin
            m_act[d][i] = 0;
            if (m_passed[d] < 65535) m_passed[d] = m_passed[d] + 1;
          end else begin
            m_age[d][i] = m_age[d][i] + 1;
          end
        end
      end
      free = -1;
      for (int i = NS - 1; i >= 0; i--) if (pre[i] == 0) free = i;
      if (m_gap[d] >= gap_lim(d) && free >= 0) begin
        m_act[d][free] = 1;
        m_age[d][free] = 0;
        m_y[d][free]   = y_of(m_lfsr[d]);
        m_lfsr[d]      = lfsr_step(m_lfsr[d]);
        m_gap[d]       = 4;
      end else begin
        m_gap[d] = (m_gap[d] + 4 > gap_lim(d)) ? gap_lim(d) : m_gap[d] + 4;
      end
    end
  endtask

  // Model advances on the same edges the DUT does.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic chk(input string name, input int d, input int i,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d slot%0d: got %0d expected %0d at %0t",
               name, d, i, act, exp, $time);
    end
  endtask

  // Whole-field compare against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NS; i++) begin
          chk("left",  d, i, int'(d != 0 ? left_b[i]  : left_a[i]),  e_left(d, i));
          chk("right", d, i, int'(d != 0 ? right_b[i] : right_a[i]), e_right(d, i));
          chk("up",    d, i, int'(d != 0 ? up_b[i]    : up_a[i]),    e_up(d, i));
          chk("down",  d, i, int'(d != 0 ? down_b[i]  : down_a[i]),  e_down(d, i));
        end
        chk("active", d, -1, int'(d != 0 ? act_b  : act_a),  e_mask(d));
        chk("passed", d, -1, int'(d != 0 ? pass_b : pass_a), m_passed[d]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    gamemode   = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_left",   0, 0, int'(left_a[0]),  640);
    chk("rst_right",  0, 0, int'(right_a[0]), 640);
    chk("rst_active", 0, -1, int'(act_a), 0);
    chk("rst_passed", 0, -1, int'(pass_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First spawn from the seed: y = 0xE1 = 225.
    gamemode = 2'b01;
    tick(1);
    chk("t1_left",   0, 0, int'(left_a[0]),  640);
    chk("t1_right",  0, 0, int'(right_a[0]), 680);
    chk("t1_up",     0, 0, int'(up_a[0]),    225);
    chk("t1_down",   0, 0, int'(down_a[0]),  265);
    chk("t1_active", 0, -1, int'(act_a), 1);
    chk("t1_park1",  0, 1, int'(right_a[1]), 640);

    // Second spawn 20 ticks later; lfsr 0x59C3 -> r=451 -> y=10.
    tick(19);
    chk("t2_nospawn", 0, -1, int'(act_a), 1);
    tick(1);
    chk("t2_left0",  0, 0, int'(left_a[0]),  560);
    chk("t2_right0", 0, 0, int'(right_a[0]), 600);
    chk("t2_left1",  0, 1, int'(left_a[1]),  640);
    chk("t2_right1", 0, 1, int'(right_a[1]), 680);
    chk("t2_up1",    0, 1, int'(up_a[1]),    10);
    chk("t2_down1",  0, 1, int'(down_a[1]),  50);
    chk("t2_active", 0, -1, int'(act_a), 3);

    // Left edge clamps at 0 while the right edge keeps scrolling.
    tick(141);
    chk("t3_clamp_l", 0, 0, int'(left_a[0]),  0);
    chk("t3_clamp_r", 0, 0, int'(right_a[0]), 36);
    tick(8);
    chk("t3_edge_r",  0, 0, int'(right_a[0]), 4);
    chk("t5_full",    1, -1, int'(act_b), 10'h3FF);
    tick(1);
    chk("t3_retire_l", 0, 0, int'(left_a[0]),  640);
    chk("t3_retire_r", 0, 0, int'(right_a[0]), 640);
    chk("t3_active",   0, -1, int'(act_a), 10'h1FE);
    chk("t3_passed",   0, -1, int'(pass_a), 1);
    chk("t5_nospawn",  1, -1, int'(act_b), 10'h3FE);
    tick(1);
    chk("t5_respawn_m", 1, -1, int'(act_b), 10'h3FF);
    chk("t5_respawn_l", 1, 0, int'(left_b[0]),  640);
    chk("t5_respawn_r", 1, 0, int'(right_b[0]), 680);

    // Pause and game-over freeze everything.
    gamemode = 2'b10;
    tick(50);
    chk("t4_pause_a", 0, -1, int'(act_a), 10'h1FE);
    chk("t4_pause_p", 0, -1, int'(pass_a), 1);
    gamemode = 2'b11;
    tick(50);
    chk("t4_over_r",  1, 0, int'(right_b[0]), 680);
    chk("t4_over_p",  1, -1, int'(pass_b), 1);

    gamemode = 2'b01;
    tick(5);

    // Menu together with a tick: field cleared, no run work.
    @(negedge clk);
    gamemode   = 2'b00;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("t6_menu_a", 0, -1, int'(act_a), 0);
    chk("t6_menu_p", 1, -1, int'(pass_b), 0);
    chk("t6_menu_r", 1, 0, int'(right_b[0]), 640);

    gamemode = 2'b01;
    tick(3);
    chk("t6_run_r", 0, 0, int'(right_a[0]), 672);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_l", 0, 0, int'(left_a[0]),  640);
    chk("t6_arst_r", 0, 0, int'(right_a[0]), 640);
    chk("t6_arst_a", 0, -1, int'(act_a), 0);
    chk("t6_arst_u", 0, 0, int'(up_a[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
